// File: rtl/serial_nibble_receiver.sv
// -----------------------------------------------------------------------------
// serial_nibble_receiver
//
// Rebuilds parallel words from the serial stream produced by the upstream
// shifting register. A frame is a start bit (1), WIDTH data bits, an optional
// even-parity bit and a stop bit (0); the idle line is low.
//
// Optional feature macro: SERIAL_RX_PARITY_EN
//   When defined, a PARITY state is inserted between DATA and STOP and the
//   PARITY_ERR output is added.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   ENB        in   sample enable; the FSM advances only when ENB=1
//   DIR        in   bit order, 0 = MSB first, 1 = LSB first (latched per frame)
//   S_IN       in   serial data
//   Q          out  last good word received
//   VALID      out  one-cycle strobe when Q updates
//   FRAME_ERR  out  last completed frame had a bad stop bit (sticky)
//   BUSY       out  FSM is not idle
//   WORD_CNT   out  count of good frames, wraps
//   PARITY_ERR out  last frame with a good stop bit had bad parity
//                   (only with SERIAL_RX_PARITY_EN)
// -----------------------------------------------------------------------------
module serial_nibble_receiver #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             FRAME_ERR,
    output logic             BUSY,
    output logic [CNT_W-1:0] WORD_CNT
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic             PARITY_ERR
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Index of the final data bit; WIDTH is at most 8 so four bits suffice.
    localparam logic [3:0] LAST_BIT  = 4'(WIDTH - 1);

`ifdef SERIAL_RX_PARITY_EN
    // Even parity over the data word: 1 when the data has an odd number of ones.
    function automatic logic even_parity(input logic [WIDTH-1:0] data);
        return ^data;
    endfunction
`endif

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] buf_q,     buf_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             dir_q,     dir_d;
    logic [WIDTH-1:0] q_q,       q_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;
    logic             busy_q,    busy_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
`ifdef SERIAL_RX_PARITY_EN
    logic             perr_q,    perr_d;
    logic             par_bad_q, par_bad_d;
`endif

    // Next-state and datapath logic for the receive FSM.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        bit_cnt_d = bit_cnt_q;
        dir_d     = dir_q;
        q_d       = q_q;
        valid_d   = 1'b0;          // strobe lasts one edge and never stretches
        ferr_d    = ferr_q;
        cnt_d     = cnt_q;
`ifdef SERIAL_RX_PARITY_EN
        perr_d    = perr_q;
        par_bad_d = par_bad_q;
`endif
        if (ENB) begin
            case (state_q)
                ST_IDLE: begin
                    if (S_IN) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 4'd0;
                        dir_d     = DIR;   // bit order is fixed for the whole frame
`ifdef SERIAL_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (dir_q) begin
                        buf_d = {S_IN, buf_q[WIDTH-1:1]};
                    end else begin
                        buf_d = {buf_q[WIDTH-2:0], S_IN};
                    end
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: begin
                    // Remember the mismatch; it is acted on only if the stop bit is good.
                    par_bad_d = even_parity(buf_q) ^ S_IN;
                    state_d   = ST_STOP;
                end
`endif
                ST_STOP: begin
                    // A high stop bit is never reused as a start bit.
                    state_d = ST_IDLE;
                    if (!S_IN) begin
`ifdef SERIAL_RX_PARITY_EN
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            q_d     = buf_q;
                            valid_d = 1'b1;
                            cnt_d   = cnt_q + CNT_W'(1);
                            ferr_d  = 1'b0;
                            perr_d  = 1'b0;
                        end
`else
                        q_d     = buf_q;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        ferr_d  = 1'b0;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;     // gated edge: everything holds, strobe drops
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            bit_cnt_q <= 4'd0;
            dir_q     <= 1'b0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef SERIAL_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            bit_cnt_q <= bit_cnt_d;
            dir_q     <= dir_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
`ifdef SERIAL_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign Q          = q_q;
    assign VALID      = valid_q;
    assign FRAME_ERR  = ferr_q;
    assign BUSY       = busy_q;
    assign WORD_CNT   = cnt_q;
`ifdef SERIAL_RX_PARITY_EN
    assign PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// -----------------------------------------------------------------------------
// Testbench for serial_nibble_receiver (WIDTH=4, CNT_W=8).
// The driver sends frames described as a list of bits and pushes the expected
// word/count into a queue; a monitor pops and compares on every VALID strobe.
// -----------------------------------------------------------------------------
module tb_serial_nibble_receiver;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             ENB;
    logic             DIR;
    logic             S_IN;
    logic [W-1:0]     Q;
    logic             VALID;
    logic             FRAME_ERR;
    logic             BUSY;
    logic [CNT_W-1:0] WORD_CNT;
`ifdef SERIAL_RX_PARITY_EN
    logic             PARITY_ERR;
`endif

    serial_nibble_receiver #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENB       (ENB),
        .DIR       (DIR),
        .S_IN      (S_IN),
        .Q         (Q),
        .VALID     (VALID),
        .FRAME_ERR (FRAME_ERR),
        .BUSY      (BUSY),
        .WORD_CNT  (WORD_CNT)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .PARITY_ERR(PARITY_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int word;
        int cnt;
    } exp_t;

    exp_t exp_fifo[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int exp_cnt  = 0;
    int exp_word = 0;
    bit exp_ferr = 1'b0;
    bit exp_perr = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // One clock with the given serial bit and enable; returns at posedge+1.
    task automatic cyc(input logic s, input logic e);
        S_IN = s;
        ENB  = e;
        @(posedge CLK);
        #1;
    endtask

    // Up to three randomly inserted gated edges carrying junk on S_IN.
    task automatic maybe_gate(input int pct);
        for (int k = 0; k < 3; k++)
            if ($urandom_range(99) < pct) cyc(1'($urandom_range(1)), 1'b0);
    endtask

    // Send a frame; bits[i] is the i-th data bit on the line.
    task automatic send_frame(input logic dir, input logic [W-1:0] bits,
                              input bit stop_bad, input bit par_bad,
                              input int gate_pct, input int gate_at);
        int w;
        DIR = dir;
        cyc(1'b1, 1'b1);
        chk("busy_after_start", int'(BUSY), 1);
        for (int i = 0; i < W; i++) begin
            if (i == gate_at) repeat (3) cyc(1'($urandom_range(1)), 1'b0);
            maybe_gate(gate_pct);
            if (gate_pct > 0) DIR = 1'($urandom_range(1));
            cyc(bits[i], 1'b1);
        end
`ifdef SERIAL_RX_PARITY_EN
        maybe_gate(gate_pct);
        cyc(1'(($countones(bits) % 2) ^ int'(par_bad)), 1'b1);
`endif
        maybe_gate(gate_pct);
        cyc(stop_bad, 1'b1);

        // Expected word: first bit is the MSB or the LSB depending on order.
        w = 0;
        for (int i = 0; i < W; i++) begin
            if (dir) w = w + int'(bits[i]) * (1 << i);
            else     w = w * 2 + int'(bits[i]);
        end
        if (stop_bad) begin
            exp_ferr = 1'b1;
        end else if (par_bad) begin
            exp_perr = 1'b1;
        end else begin
            exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
            exp_word = w;
            exp_ferr = 1'b0;
            exp_perr = 1'b0;
            exp_fifo.push_back('{word: w, cnt: exp_cnt});
        end
        chk("frame_err", int'(FRAME_ERR), int'(exp_ferr));
        chk("q_after_frame", int'(Q), exp_word);
        chk("busy_after_stop", int'(BUSY), 0);
`ifdef SERIAL_RX_PARITY_EN
        chk("parity_err", int'(PARITY_ERR), int'(exp_perr));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_q"}, int'(Q), 0);
        chk({tag, "_valid"}, int'(VALID), 0);
        chk({tag, "_ferr"}, int'(FRAME_ERR), 0);
        chk({tag, "_busy"}, int'(BUSY), 0);
        chk({tag, "_cnt"}, int'(WORD_CNT), 0);
`ifdef SERIAL_RX_PARITY_EN
        chk({tag, "_perr"}, int'(PARITY_ERR), 0);
`endif
    endtask

    // Monitor: each VALID edge must match the oldest expected word.
    always @(negedge CLK) begin
        if (VALID === 1'b1) begin
            if (exp_fifo.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_fifo.pop_front();
                chk("mon_q", int'(Q), e.word);
                chk("mon_word_cnt", int'(WORD_CNT), e.cnt);
            end
        end
    end

    initial begin
        RESET = 1'b1;
        ENB   = 1'b0;
        DIR   = 1'b0;
        S_IN  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_state("reset");
        RESET = 1'b0;
        cyc(1'b0, 1'b1);

        // Line 1,1,0,1,1,0 MSB first -> 1011
        send_frame(1'b0, 4'b1101, 1'b0, 1'b0, 0, -1);
        chk("tp_msb_q", int'(Q), 4'b1011);
        // Same line LSB first -> 1101 (back-to-back, no idle gap)
        send_frame(1'b1, 4'b1101, 1'b0, 1'b0, 0, -1);
        chk("tp_lsb_q", int'(Q), 4'b1101);
        // Bad stop bit keeps Q, then a good 0011 clears the error
        send_frame(1'b0, 4'b1010, 1'b1, 1'b0, 0, -1);
        chk("tp_badstop_q_hold", int'(Q), 4'b1101);
        cyc(1'b0, 1'b1);
        send_frame(1'b0, 4'b1100, 1'b0, 1'b0, 0, -1);
        chk("tp_0011_q", int'(Q), 4'b0011);
        // Three gated edges after the second data bit
        send_frame(1'b0, 4'b1111, 1'b0, 1'b0, 0, 2);
        chk("tp_gated_q", int'(Q), 4'b1111);

        // Reset in the middle of a frame discards it
        DIR = 1'b0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        #2 RESET = 1'b1;
        #1;
        check_reset_state("mid_reset");
        RESET = 1'b0;
        exp_cnt = 0; exp_word = 0; exp_ferr = 1'b0; exp_perr = 1'b0;
        cyc(1'b0, 1'b1);
        send_frame(1'b0, 4'b1000, 1'b0, 1'b0, 0, -1);
        chk("tp_after_reset_q", int'(Q), 4'b0001);
        chk("tp_after_reset_cnt", int'(WORD_CNT), 1);

`ifdef SERIAL_RX_PARITY_EN
        // Data 1011 with parity bit 0 is wrong; with 1 it is accepted
        send_frame(1'b0, 4'b1101, 1'b0, 1'b1, 0, -1);
        chk("tp_par_bad_q_hold", int'(Q), 4'b0001);
        send_frame(1'b0, 4'b1101, 1'b0, 1'b0, 0, -1);
        chk("tp_par_good_q", int'(Q), 4'b1011);
`endif

        // Random frames; enough good ones to wrap the counter
        repeat (400) begin
            bit sb;
            bit pb;
            sb = ($urandom_range(9) == 0);
`ifdef SERIAL_RX_PARITY_EN
            pb = ($urandom_range(9) == 0);
`else
            pb = 1'b0;
`endif
            send_frame(1'($urandom_range(1)), 4'($urandom_range(15)), sb, pb, 20, -1);
            repeat ($urandom_range(2)) cyc(1'b0, 1'b1);
        end

        repeat (3) cyc(1'b0, 1'b1);
        chk("fifo_drained", exp_fifo.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
